spi_response_arbiter: RTL and testbench
=======================================

Name: spi_response_arbiter

Overview:
Shares the single SPI read-back path between all register-bearing blocks (camera, chip ID, graphics, future peripherals). Sits between the responders and spi_peripheral's response input in the SPI clock domain. Per transaction it locks onto one responder, forwards its bytes, and supplies a default byte on timeout. It also answers its own status opcode with saturating collision/timeout counts.

Parameters:
NUM_REQUESTERS, 4, number of responder ports (2..8)
TIMEOUT_CYCLES, 16, cycles after opcode_valid rise with no responder valid before the default byte is returned (≥2)
STATUS_ADDRESS, 'hDC, opcode the arbiter answers itself
DEFAULT_RESPONSE, 'h00, byte returned on timeout

Ports:
clock_in  in  1  SPI-domain clock
reset_n_in  in  1  asynchronous, active-low reset
opcode_in  in  8  current opcode from spi_peripheral
opcode_valid_in  in  1  high for the whole transaction after the opcode byte
response_in  in  8*NUM_REQUESTERS  responder bytes, requester i at [8i+7:8i]
response_valid_in  in  NUM_REQUESTERS  per-requester valid
response_out  out  8  byte to spi_peripheral
response_valid_out  out  1  response_out valid
grant_out  out  NUM_REQUESTERS  one-hot current grant, 0 when none
timeout_pulse_out  out  1  one-cycle pulse on timeout
collision_pulse_out  out  1  one-cycle pulse when >1 valid at grant time

Behaviour:
- Reset (async assert, sync release): state IDLE; response_out 0; response_valid_out 0; grant_out 0; pulses 0; collision_count 0; timeout_count 0; rr_pointer 0.
- States: IDLE, WAIT, GRANT, SELF, DEFAULT.
- IDLE: on opcode_valid_in rising (registered previous value): opcode_in == STATUS_ADDRESS -> SELF; else -> WAIT, timer cleared.
- WAIT: timer increments each cycle. Any response_valid_in set -> pick winner round-robin starting at rr_pointer (first set bit at index ≥ rr_pointer, wrapping); grant_out = onehot(winner); rr_pointer = winner+1 mod NUM_REQUESTERS; -> GRANT. Same cycle, >1 bit set -> collision_pulse_out 1 and collision_count +1 (saturate 15). Timer reaching TIMEOUT_CYCLES-1 with no valid -> DEFAULT, timeout_pulse_out 1, timeout_count +1 (saturate 15). Valid arriving in the timeout cycle wins (grant takes priority).
- GRANT: response_out/response_valid_out register the granted requester's byte/valid; latency 1 cycle from response_valid_in to response_valid_out. Other requesters ignored.
- SELF: response_out = {collision_count, timeout_count}, response_valid_out 1, from cycle after entry. Counts frozen while in SELF; both cleared on exit from SELF (read-to-clear).
- DEFAULT: response_out = DEFAULT_RESPONSE, response_valid_out 1.
- Any non-IDLE state: opcode_valid_in low -> IDLE next cycle; response_valid_out 0, grant_out 0 in that same next cycle. Counters keep value except SELF exit clear.
- opcode_valid_in falling and rising in adjacent cycles: must pass through IDLE for ≥1 cycle; new rise detected from IDLE edge register.
- Responder valid while IDLE: ignored, no counters change.
- Reset mid-transaction: immediate return to reset values; transaction not resumed.
- Counts 4 bits each, saturating at 15; no wrap.

Decomposition:
- Package spi_arbiter_pkg: state enum (IDLE, WAIT, GRANT, SELF, DEFAULT), COUNT_WIDTH = 4, COUNT_MAX = 15.
- Sub-module round_robin_select: combinational, inputs request vector + pointer, outputs one-hot grant, winner index, multiple-request flag. Registered state stays in spi_response_arbiter.

Test Plan:
- Opcode 'hDB, requester 1 valid byte 'h81 3 cycles after rise -> grant_out 'b0010, response_out 'h81 valid 1 cycle later, no pulses.
- Requesters 0 and 2 valid same cycle, rr_pointer 0 -> grant 0, collision pulse, rr_pointer 1; repeat -> grant 2.
- Unknown opcode 'h55, no valid for 16 cycles -> timeout pulse at cycle 16, response_out 'h00 valid until opcode_valid low.
- After 2 collisions and 3 timeouts, opcode 'hDC -> response_out 'h23; next 'hDC read -> 'h00.
- 20 timeouts then 'hDC read -> 'h0F (saturated).
- reset_n_in low during GRANT -> response_valid_out and grant_out 0 immediately; after release, new transaction arbitrates from rr_pointer 0.

Source files
------------

// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI response arbiter.
// Contents:
//   arb_state_e  - arbiter FSM states
//   COUNT_WIDTH  - width of the collision/timeout event counters
//   COUNT_MAX    - saturation value of those counters
//   sat_inc()    - saturating increment for the event counters
package spi_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StGrant,
        StSelf,
        StDefault
    } arb_state_e;

    localparam int unsigned COUNT_WIDTH = 4;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = 4'd15;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        return (value == COUNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/round_robin_select.sv
// Combinational round-robin picker.
// Ports:
//   request_i  - request vector, one bit per requester
//   pointer_i  - index that gets first priority this round
//   grant_o    - one-hot winner (all zero when no request)
//   winner_o   - binary index of the winner
//   any_o      - at least one request present
//   multiple_o - more than one request present
module round_robin_select #(
    parameter int unsigned NUM_REQUESTERS = 4,
    parameter int unsigned IDX_WIDTH      = 2
) (
    input  logic [NUM_REQUESTERS-1:0] request_i,
    input  logic [IDX_WIDTH-1:0]      pointer_i,
    output logic [NUM_REQUESTERS-1:0] grant_o,
    output logic [IDX_WIDTH-1:0]      winner_o,
    output logic                      any_o,
    output logic                      multiple_o
);

    logic        found;
    int unsigned req_count;

    // Two passes: indices at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
            if (!found && request_i[i] && (i >= int'(pointer_i))) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                winner_o   = IDX_WIDTH'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
            if (!found && request_i[i] && (i < int'(pointer_i))) begin
                found      = 1'b1;
                grant_o[i] = 1'b1;
                winner_o   = IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        req_count = 0;
        for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
            if (request_i[i]) begin
                req_count = req_count + 1;
            end
        end
        multiple_o = (req_count > 1);
        any_o      = |request_i;
    end

endmodule

// File: rtl/spi_response_arbiter.sv
// Shares the SPI read-back path between register-bearing responders.
// Per transaction it locks onto one responder (round-robin), forwards its bytes,
// returns DEFAULT_RESPONSE if nobody answers in time, and answers STATUS_ADDRESS
// itself with {collision_count, timeout_count} (cleared when that read ends).
// Ports:
//   clock_in, reset_n_in       - SPI-domain clock, async active-low reset
//   opcode_in, opcode_valid_in - current opcode and transaction-active flag
//   response_in                - responder bytes, requester i at [8i+7:8i]
//   response_valid_in          - per-requester valid
//   response_out/_valid_out    - registered byte to spi_peripheral
//   grant_out                  - one-hot current grant, 0 when none
//   timeout_pulse_out          - one-cycle pulse on timeout
//   collision_pulse_out        - one-cycle pulse when >1 valid at grant time
module spi_response_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS   = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 16,
    parameter logic [7:0]  STATUS_ADDRESS   = 8'hDC,
    parameter logic [7:0]  DEFAULT_RESPONSE = 8'h00
) (
    input  logic                        clock_in,
    input  logic                        reset_n_in,
    input  logic [7:0]                  opcode_in,
    input  logic                        opcode_valid_in,
    input  logic [8*NUM_REQUESTERS-1:0] response_in,
    input  logic [NUM_REQUESTERS-1:0]   response_valid_in,
    output logic [7:0]                  response_out,
    output logic                        response_valid_out,
    output logic [NUM_REQUESTERS-1:0]   grant_out,
    output logic                        timeout_pulse_out,
    output logic                        collision_pulse_out
);

    localparam int unsigned RR_WIDTH    = $clog2(NUM_REQUESTERS);
    localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [RR_WIDTH-1:0]    RR_LAST    = RR_WIDTH'(NUM_REQUESTERS - 1);

    arb_state_e                  state_q, state_d;
    logic                        opcode_valid_q, opcode_valid_d;
    logic [TIMER_WIDTH-1:0]      timer_q, timer_d;
    logic [RR_WIDTH-1:0]         rr_ptr_q, rr_ptr_d;
    logic [RR_WIDTH-1:0]         grant_idx_q, grant_idx_d;
    logic [NUM_REQUESTERS-1:0]   grant_q, grant_d;
    logic [7:0]                  resp_q, resp_d;
    logic                        resp_valid_q, resp_valid_d;
    logic                        timeout_pulse_q, timeout_pulse_d;
    logic                        collision_pulse_q, collision_pulse_d;
    logic [COUNT_WIDTH-1:0]      collision_count_q, collision_count_d;
    logic [COUNT_WIDTH-1:0]      timeout_count_q, timeout_count_d;

    logic [NUM_REQUESTERS-1:0]   rr_grant;
    logic [RR_WIDTH-1:0]         rr_winner;
    logic                        rr_any;
    logic                        rr_multiple;
    logic                        opcode_rise;
    logic [7:0]                  resp_bytes [NUM_REQUESTERS];

    round_robin_select #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .IDX_WIDTH      (RR_WIDTH)
    ) u_rr_select (
        .request_i  (response_valid_in),
        .pointer_i  (rr_ptr_q),
        .grant_o    (rr_grant),
        .winner_o   (rr_winner),
        .any_o      (rr_any),
        .multiple_o (rr_multiple)
    );

    always_comb begin
        for (int i = 0; i < int'(NUM_REQUESTERS); i++) begin
            resp_bytes[i] = response_in[8*i +: 8];
        end
    end

    // Rise is only acted on from StIdle, so a drop-then-rise always costs one idle cycle.
    assign opcode_rise = opcode_valid_in && !opcode_valid_q;

    always_comb begin
        state_d           = state_q;
        opcode_valid_d    = opcode_valid_in;
        timer_d           = timer_q;
        rr_ptr_d          = rr_ptr_q;
        grant_idx_d       = grant_idx_q;
        grant_d           = grant_q;
        resp_d            = resp_q;
        resp_valid_d      = resp_valid_q;
        timeout_pulse_d   = 1'b0;
        collision_pulse_d = 1'b0;
        collision_count_d = collision_count_q;
        timeout_count_d   = timeout_count_q;

        if ((state_q != StIdle) && !opcode_valid_in) begin
            state_d      = StIdle;
            grant_d      = '0;
            resp_d       = '0;
            resp_valid_d = 1'b0;
            // Status read-to-clear.
            if (state_q == StSelf) begin
                collision_count_d = '0;
                timeout_count_d   = '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (opcode_rise) begin
                        if (opcode_in == STATUS_ADDRESS) begin
                            state_d = StSelf;
                        end else begin
                            state_d = StWait;
                            timer_d = '0;
                        end
                    end
                end
                StWait: begin
                    // A valid in the last waiting cycle still wins over the timeout.
                    if (rr_any) begin
                        state_d      = StGrant;
                        grant_d      = rr_grant;
                        grant_idx_d  = rr_winner;
                        rr_ptr_d     = (rr_winner == RR_LAST) ? '0 : rr_winner + 1'b1;
                        resp_d       = resp_bytes[rr_winner];
                        resp_valid_d = 1'b1;
                        if (rr_multiple) begin
                            collision_pulse_d = 1'b1;
                            collision_count_d = sat_inc(collision_count_q);
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        state_d         = StDefault;
                        resp_d          = DEFAULT_RESPONSE;
                        resp_valid_d    = 1'b1;
                        timeout_pulse_d = 1'b1;
                        timeout_count_d = sat_inc(timeout_count_q);
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StGrant: begin
                    resp_d       = resp_bytes[grant_idx_q];
                    resp_valid_d = response_valid_in[grant_idx_q];
                end
                StSelf: begin
                    resp_d       = {collision_count_q, timeout_count_q};
                    resp_valid_d = 1'b1;
                end
                StDefault: begin
                    resp_d       = DEFAULT_RESPONSE;
                    resp_valid_d = 1'b1;
                end
                default: begin
                    state_d      = StIdle;
                    grant_d      = '0;
                    resp_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q           <= StIdle;
            opcode_valid_q    <= 1'b0;
            timer_q           <= '0;
            rr_ptr_q          <= '0;
            grant_idx_q       <= '0;
            grant_q           <= '0;
            resp_q            <= '0;
            resp_valid_q      <= 1'b0;
            timeout_pulse_q   <= 1'b0;
            collision_pulse_q <= 1'b0;
            collision_count_q <= '0;
            timeout_count_q   <= '0;
        end else begin
            state_q           <= state_d;
            opcode_valid_q    <= opcode_valid_d;
            timer_q           <= timer_d;
            rr_ptr_q          <= rr_ptr_d;
            grant_idx_q       <= grant_idx_d;
            grant_q           <= grant_d;
            resp_q            <= resp_d;
            resp_valid_q      <= resp_valid_d;
            timeout_pulse_q   <= timeout_pulse_d;
            collision_pulse_q <= collision_pulse_d;
            collision_count_q <= collision_count_d;
            timeout_count_q   <= timeout_count_d;
        end
    end

    assign response_out        = resp_q;
    assign response_valid_out  = resp_valid_q;
    assign grant_out           = grant_q;
    assign timeout_pulse_out   = timeout_pulse_q;
    assign collision_pulse_out = collision_pulse_q;

endmodule

// File: tb/tb_spi_response_arbiter.sv
// Self-checking bench for spi_response_arbiter: a table of transactions whose expected
// first-response is queued on drive and popped when response_valid_out rises, plus
// hand-written sequences for saturation, idle noise, byte forwarding and mid-grant reset.
module tb_spi_response_arbiter;

    localparam int unsigned N      = 4;
    localparam int unsigned TMO    = 16;
    localparam logic [7:0]  STATUS = 8'hDC;

    logic             clock_in = 1'b0;
    logic             reset_n_in;
    logic [7:0]       opcode_in;
    logic             opcode_valid_in;
    logic [8*N-1:0]   response_in;
    logic [N-1:0]     response_valid_in;
    logic [7:0]       response_out;
    logic             response_valid_out;
    logic [N-1:0]     grant_out;
    logic             timeout_pulse_out;
    logic             collision_pulse_out;

    always #5 clock_in = ~clock_in;

    spi_response_arbiter #(
        .NUM_REQUESTERS   (N),
        .TIMEOUT_CYCLES   (TMO),
        .STATUS_ADDRESS   (STATUS),
        .DEFAULT_RESPONSE (8'h00)
    ) dut (
        .clock_in            (clock_in),
        .reset_n_in          (reset_n_in),
        .opcode_in           (opcode_in),
        .opcode_valid_in     (opcode_valid_in),
        .response_in         (response_in),
        .response_valid_in   (response_valid_in),
        .response_out        (response_out),
        .response_valid_out  (response_valid_out),
        .grant_out           (grant_out),
        .timeout_pulse_out   (timeout_pulse_out),
        .collision_pulse_out (collision_pulse_out)
    );

    typedef struct {
        logic [7:0]  opcode;
        logic [N-1:0] mask;
        int unsigned delay;
        logic [N-1:0] grant;
        logic [7:0]  resp;
        logic        coll;
        logic        tmo;
    } vec_t;

    typedef struct {
        logic [N-1:0] grant;
        logic [7:0]  resp;
        logic        coll;
        logic        tmo;
        int unsigned lat;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[13];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [N-1:0] m, input int unsigned d,
                                input logic [N-1:0] g, input logic [7:0] r, input logic c,
                                input logic t);
        vec_t v;
        v.opcode = op; v.mask = m; v.delay = d; v.grant = g; v.resp = r; v.coll = c; v.tmo = t;
        return v;
    endfunction

    // One transaction: rise opcode_valid, optionally raise responder valids after 'delay'
    // cycles, wait for the first valid response, check it, check it holds, then release.
    task automatic run_vec(input vec_t v);
        exp_t        e;
        exp_t        got;
        int unsigned cycles;
        e.grant = v.grant; e.resp = v.resp; e.coll = v.coll; e.tmo = v.tmo;
        if (v.opcode == STATUS)      e.lat = 2;
        else if (v.mask != '0)       e.lat = v.delay + 2;
        else                         e.lat = TMO + 1;
        sb_q.push_back(e);

        opcode_in       = v.opcode;
        opcode_valid_in = 1'b1;
        step();
        cycles = 1;
        if (v.mask != '0) begin
            repeat (v.delay) begin
                step();
                cycles++;
            end
            response_valid_in = v.mask;
        end
        while (!response_valid_out && cycles < 40) begin
            step();
            cycles++;
        end

        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'(sb_q.size()), 1);
        end else begin
            got = sb_q.pop_front();
            if (!response_valid_out) begin
                check("valid_wait", 32'(response_valid_out), 1);
            end else begin
                check("latency", cycles, got.lat);
                check("response", 32'(response_out), 32'(got.resp));
                check("grant", 32'(grant_out), 32'(got.grant));
                check("collision_pulse", 32'(collision_pulse_out), 32'(got.coll));
                check("timeout_pulse", 32'(timeout_pulse_out), 32'(got.tmo));
            end
        end

        step();
        check("hold_valid_pulses",
              32'({response_valid_out, collision_pulse_out, timeout_pulse_out}), 32'b100);

        opcode_valid_in   = 1'b0;
        response_valid_in = '0;
        step();
        check("release", 32'({response_valid_out, grant_out}), 0);
    endtask

    initial begin
        // rr pointer / counts tracked by hand: comments show state after each entry.
        vecs[0]  = mk(8'h10, 4'b0101, 0, 4'b0001, 8'h80, 1'b1, 1'b0); // rr1 c1
        vecs[1]  = mk(8'h11, 4'b0101, 1, 4'b0100, 8'h82, 1'b1, 1'b0); // rr3 c2
        vecs[2]  = mk(8'hDB, 4'b0010, 3, 4'b0010, 8'h81, 1'b0, 1'b0); // rr2
        vecs[3]  = mk(8'h55, 4'b0000, 0, 4'b0000, 8'h00, 1'b0, 1'b1); // t1
        vecs[4]  = mk(8'h56, 4'b0000, 0, 4'b0000, 8'h00, 1'b0, 1'b1); // t2
        vecs[5]  = mk(8'h57, 4'b0000, 0, 4'b0000, 8'h00, 1'b0, 1'b1); // t3
        vecs[6]  = mk(STATUS, 4'b0000, 0, 4'b0000, 8'h23, 1'b0, 1'b0); // clears
        vecs[7]  = mk(STATUS, 4'b0000, 0, 4'b0000, 8'h00, 1'b0, 1'b0);
        vecs[8]  = mk(8'h20, 4'b1001, 2, 4'b1000, 8'h83, 1'b1, 1'b0); // rr0 c1
        vecs[9]  = mk(8'h21, 4'b1110, 0, 4'b0010, 8'h81, 1'b1, 1'b0); // rr2 c2
        vecs[10] = mk(8'h22, 4'b1111, 5, 4'b0100, 8'h82, 1'b1, 1'b0); // rr3 c3
        vecs[11] = mk(8'h23, 4'b1000, 15, 4'b1000, 8'h83, 1'b0, 1'b0); // valid in timeout cycle
        vecs[12] = mk(STATUS, 4'b0000, 0, 4'b0000, 8'h30, 1'b0, 1'b0);

        reset_n_in        = 1'b0;
        opcode_in         = 8'h00;
        opcode_valid_in   = 1'b0;
        response_in       = {8'h83, 8'h82, 8'h81, 8'h80};
        response_valid_in = '0;
        step();
        step();
        check("reset_outputs",
              32'({response_out, response_valid_out, grant_out, timeout_pulse_out,
                   collision_pulse_out}), 0);
        reset_n_in = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i]);
        end

        // Saturation: 20 timeouts read back as 15.
        for (int i = 0; i < 20; i++) begin
            run_vec(mk(8'h60, 4'b0000, 0, 4'b0000, 8'h00, 1'b0, 1'b1));
        end
        run_vec(mk(STATUS, 4'b0000, 0, 4'b0000, 8'h0F, 1'b0, 1'b0));

        // Responder valids while idle are ignored and touch no counters.
        response_valid_in = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_ignore",
                  32'({response_valid_out, grant_out, collision_pulse_out, timeout_pulse_out}), 0);
        end
        response_valid_in = '0;
        run_vec(mk(STATUS, 4'b0000, 0, 4'b0000, 8'h00, 1'b0, 1'b0));

        // Leave a timeout count behind so the reset below must clear it.
        run_vec(mk(8'h61, 4'b0000, 0, 4'b0000, 8'h00, 1'b0, 1'b1));

        // Byte forwarding during GRANT, then reset mid-grant (rr pointer is 0 here).
        opcode_in         = 8'h30;
        opcode_valid_in   = 1'b1;
        step();
        response_valid_in = 4'b0100;
        step();
        check("fwd_first", 32'({grant_out, response_out, response_valid_out}),
              32'({4'b0100, 8'h82, 1'b1}));
        response_in[23:16] = 8'hA5;
        response_in[7:0]   = 8'h5A;
        response_valid_in  = 4'b0101;
        step();
        check("fwd_follow", 32'({grant_out, response_out, response_valid_out, collision_pulse_out}),
              32'({4'b0100, 8'hA5, 1'b1, 1'b0}));
        response_valid_in = 4'b0001;
        step();
        check("fwd_other_ignored", 32'({grant_out, response_valid_out}), 32'({4'b0100, 1'b0}));
        response_valid_in = 4'b0100;
        step();
        check("fwd_valid_again", 32'(response_valid_out), 1);
        reset_n_in = 1'b0;
        #1;
        check("async_reset", 32'({response_valid_out, grant_out}), 0);
        opcode_valid_in   = 1'b0;
        response_valid_in = '0;
        response_in       = {8'h83, 8'h82, 8'h81, 8'h80};
        step();
        reset_n_in = 1'b1;
        step();

        // rr pointer back at 0 -> requester 1 wins over 3; counts restart from zero.
        run_vec(mk(8'h31, 4'b1010, 0, 4'b0010, 8'h81, 1'b1, 1'b0));
        run_vec(mk(STATUS, 4'b0000, 0, 4'b0000, 8'h10, 1'b0, 1'b0));

        check("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
